// File: rtl/instr_pkg.sv
// Shared RV32I encode/decode constants: format codes, opcodes, NOP word and
// encoder FSM state encodings.
package instr_pkg;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_LOAD = 3'd2,
        FMT_S    = 3'd3,
        FMT_B    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NOP  = 3'd6,
        FMT_ILL  = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_J    = 7'b1101111;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } enc_state_e;

    typedef struct packed {
        fmt_e        fmt;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [20:0] imm;
    } instr_fields_t;

    typedef struct packed {
        logic [31:0] word;
        logic        err;
    } enc_result_t;

endpackage

// File: rtl/instr_fifo.sv
// DEPTH-entry synchronous FIFO; pointers carry an extra wrap bit so full and
// empty are distinguishable without a separate occupancy counter.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [AW:0]             wr_ptr;
    logic [AW:0]             rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Storage is cleared on reset so the exposed head reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && (!full || pop)) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded fields into RV32I words and streams them into IMEM.
// Optional INSTR_ENCODER_RANGE_CHECK_EN flags immediates that do not fit.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        fmt,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [20:0]       imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ready,
    output logic              done,
    output logic              err,
    output logic [15:0]       count
);

    function automatic enc_result_t encode(input instr_fields_t f);
        enc_result_t r;
        r.word = NOP_WORD;
        r.err  = 1'b0;
        case (f.fmt)
            FMT_R:    r.word = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, OP_R};
            FMT_I:    r.word = {f.imm[11:0], f.rs1, f.funct3, f.rd, OP_I};
            FMT_LOAD: r.word = {f.imm[11:0], f.rs1, f.funct3, f.rd, OP_LOAD};
            FMT_S:    r.word = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], OP_S};
            FMT_B:    r.word = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                                f.imm[4:1], f.imm[11], OP_B};
            FMT_J:    r.word = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, OP_J};
            FMT_NOP:  r.word = NOP_WORD;
            default:  r.err  = 1'b1;
        endcase
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        // Out-of-range or odd branch/jump offsets are still packed (truncated).
        case (f.fmt)
            FMT_I, FMT_LOAD, FMT_S:
                if (f.imm[20:11] != {10{f.imm[11]}}) r.err = 1'b1;
            FMT_B:
                if ((f.imm[20:12] != {9{f.imm[12]}}) || f.imm[0]) r.err = 1'b1;
            FMT_J:
                if (f.imm[0]) r.err = 1'b1;
            default: ;
        endcase
`endif
        return r;
    endfunction

    enc_state_e    state, state_nx;
    instr_fields_t fields;
    enc_result_t   enc;
    logic          fifo_full, fifo_empty;
    logic          push, pop;

    assign fields = '{fmt: fmt_e'(fmt), funct3: funct3, funct7: funct7,
                      rd: rd, rs1: rs1, rs2: rs2, imm: imm};
    assign enc    = encode(fields);

    // in_ready looks only at registered full, never at imem_ready.
    assign in_ready = (state == ST_RUN) && !fifo_full;
    assign push     = in_valid && in_ready;
    assign imem_we  = !fifo_empty && ((state == ST_RUN) || (state == ST_DRAIN));
    assign pop      = imem_we && imem_ready;
    assign done     = (state == ST_DONE);

    instr_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (enc.word),
        .pop   (pop),
        .dout  (imem_wdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start) state_nx = ST_RUN;
            ST_RUN:   if (push && in_last) state_nx = ST_DRAIN;
            ST_DRAIN: if (fifo_empty) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_addr <= '0;
            count     <= '0;
            err       <= 1'b0;
        end else if ((state == ST_IDLE) && start) begin
            imem_addr <= base_addr & ~ADDR_W'(3);
            count     <= '0;
            err       <= 1'b0;
        end else begin
            if (pop) begin
                imem_addr <= imem_addr + ADDR_W'(4);
                if (count != 16'hFFFF) count <= count + 16'd1;
            end
            if (push && enc.err) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, backpressure, wrap, err, reset.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [2:0]  fmt;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [20:0] imm;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        imem_ready;
    logic        done;
    logic        err;
    logic [15:0] count;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] wq[$];

    instr_encoder #(.DEPTH(4), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .fmt(fmt), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1),
        .rs2(rs2), .imm(imm), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .imem_ready(imem_ready), .done(done),
        .err(err), .count(count)
    );

    always #5 clk = ~clk;

    // Writes that will complete on the coming rising edge.
    always @(negedge clk)
        if (rst_n && imem_we && imem_ready) wq.push_back({imem_addr, imem_wdata});

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_start(input logic [31:0] base);
        wq.delete();
        start = 1'b1; base_addr = base;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [2:0] f, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [20:0] im, input logic last);
        logic ok;
        ok = 1'b0;
        fmt = f; funct3 = f3; funct7 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
        in_last = last; in_valid = 1'b1;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk); ok = in_ready;
            tick();
        end
        if (!ok) chk("accept_timeout", 0, 1);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk); seen = done;
        end
        chk("done_pulse", seen, 1);
        tick();
    endtask

    task automatic chk_wr(input int idx, input logic [31:0] a, input logic [31:0] d);
        if (idx < wq.size()) chk($sformatf("write%0d", idx), wq[idx], {a, d});
        else                 chk($sformatf("write%0d_missing", idx), 0, 1);
    endtask

    logic exp_range_err;

    initial begin
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        exp_range_err = 1'b1;
`else
        exp_range_err = 1'b0;
`endif
        rst_n = 1'b0; start = 0; base_addr = 0; in_valid = 0; in_last = 0;
        fmt = 0; funct3 = 0; funct7 = 0; rd = 0; rs1 = 0; rs2 = 0; imm = 0;
        imem_ready = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_we", imem_we, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_count", count, 0);
        rst_n = 1'b1;
        tick();

        // Single addi x1, x0, 5
        do_start(32'h100);
        send(3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 21'd5, 1'b1);
        wait_done();
        chk("t1_nwr", wq.size(), 1);
        chk_wr(0, 32'h100, 32'h0050_0093);
        chk("t1_count", count, 1);
        chk("t1_err", err, 0);

        // R, S, B, J, negative-offset B
        do_start(32'h200);
        send(3'd0, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 21'd0, 1'b0);
        send(3'd3, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 21'd8, 1'b0);
        send(3'd4, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 21'd8, 1'b0);
        send(3'd5, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 21'd16, 1'b0);
        send(3'd4, 3'd1, 7'd0, 5'd0, 5'd1, 5'd2, 21'h1FFFFC, 1'b1);
        wait_done();
        chk("t2_nwr", wq.size(), 5);
        chk_wr(0, 32'h200, 32'h0020_81B3);
        chk_wr(1, 32'h204, 32'h0020_A423);
        chk_wr(2, 32'h208, 32'h0020_8463);
        chk_wr(3, 32'h20C, 32'h0100_00EF);
        chk_wr(4, 32'h210, 32'hFE20_9EE3);
        chk("t2_count", count, 5);
        chk("t2_err", err, 0);

        // Backpressure: 4 fill the FIFO, 5th must wait
        imem_ready = 1'b0;
        do_start(32'h300);
        for (int k = 1; k <= 4; k++)
            send(3'd1, 3'd0, 7'd0, 5'(k), 5'd0, 5'd0, 21'(k), 1'b0);
        @(negedge clk);
        chk("bp_full_ready", in_ready, 0);
        chk("bp_we", imem_we, 1);
        chk("bp_addr", imem_addr, 32'h300);
        chk("bp_wdata", imem_wdata, 32'h0010_0093);
        tick();
        start = 1'b1; base_addr = 32'h900;
        tick();
        start = 1'b0;
        tick();
        @(negedge clk);
        chk("bp_hold_addr", imem_addr, 32'h300);
        chk("bp_hold_wdata", imem_wdata, 32'h0010_0093);
        chk("bp_hold_we", imem_we, 1);
        chk("bp_no_writes", wq.size(), 0);
        tick();
        imem_ready = 1'b1;
        send(3'd1, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 21'd5, 1'b1);
        wait_done();
        chk("bp_nwr", wq.size(), 5);
        for (int k = 1; k <= 5; k++)
            chk_wr(k - 1, 32'h300 + 32'(4 * (k - 1)),
                   (32'(k) << 20) | (32'(k) << 7) | 32'h13);
        chk("bp_count", count, 5);

        // Illegal fmt, range check, address wrap with unaligned base
        do_start(32'hFFFF_FFFE);
        send(3'd7, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 21'd0, 1'b0);
        @(negedge clk);
        chk("ill_err", err, 1);
        tick();
        send(3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 21'd2048, 1'b1);
        wait_done();
        chk_wr(0, 32'hFFFF_FFFC, 32'h0000_0013);
        chk_wr(1, 32'h0000_0000, 32'h8000_0093);
        chk("ill_count", count, 2);
        do_start(32'h400);
        chk("start_clr_err", err, 0);
        send(3'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 21'd2048, 1'b1);
        wait_done();
        chk("range_err", err, exp_range_err);
        chk_wr(0, 32'h400, 32'h8000_0093);

        // Reset while draining with 2 words queued
        imem_ready = 1'b0;
        do_start(32'h600);
        send(3'd6, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 21'd0, 1'b0);
        send(3'd6, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 21'd0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mr_we", imem_we, 0);
        chk("mr_addr", imem_addr, 0);
        chk("mr_wdata", imem_wdata, 0);
        chk("mr_count", count, 0);
        chk("mr_done", done, 0);
        chk("mr_in_ready", in_ready, 0);
        tick();
        rst_n = 1'b1;
        imem_ready = 1'b1;
        repeat (3) tick();
        chk("mr_no_writes", wq.size(), 0);
        do_start(32'h500);
        send(3'd6, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 21'd0, 1'b1);
        wait_done();
        chk("mr_nwr", wq.size(), 1);
        chk_wr(0, 32'h500, 32'h0000_0013);
        chk("mr_count_after", count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the pipeline's control/decode unit: accepts decoded instruction fields and packs them into 32-bit RV32I machine words.
- Encoded words are buffered in a small FIFO and streamed into instruction memory at sequential word addresses.
- Used by the test/boot path to load programs into IMEM before the 5-stage pipeline runs.
- Covers the formats the decoder handles: R, I (addi/lw), S, B, J, plus NOP.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- ADDR_W, 32, IMEM byte-address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches base_addr and leaves IDLE.
- base_addr  in  ADDR_W  first IMEM byte address; bits [1:0] are ignored (forced to 0).
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- in_last  in  1  marks the final bundle of the program.
- fmt  in  3  format: 0=R, 1=I, 2=LOAD, 3=S, 4=B, 5=J, 6=NOP, 7=illegal.
- funct3  in  3  funct3 field.
- funct7  in  7  funct7 field (R only).
- rd  in  5  destination register.
- rs1  in  5  source register 1.
- rs2  in  5  source register 2.
- imm  in  21  signed byte immediate; bit 0 is ignored for B and J.
- imem_we  out  1  IMEM write strobe.
- imem_addr  out  ADDR_W  IMEM write byte address.
- imem_wdata  out  32  encoded instruction word.
- imem_ready  in  1  IMEM accepts the write this cycle.
- done  out  1  one-cycle pulse once the last word has been written.
- err  out  1  sticky error flag; cleared by start.
- count  out  16  number of words written since start.

Behaviour:
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, done=0, err=0, count=0, FIFO empty, state IDLE.
- State machine:
  - IDLE -> RUN on start.
  - RUN -> DRAIN when a bundle with in_last is accepted.
  - DRAIN -> DONE when the FIFO is empty and no write is pending.
  - DONE -> IDLE unconditionally after 1 cycle; done=1 only in DONE.
  - start is ignored outside IDLE.
- Input handshake:
  - in_ready = (state==RUN) && FIFO not full.
  - A bundle transfers when in_valid && in_ready.
  - Fields are encoded combinationally and pushed into the FIFO in the same cycle.
- Encoding (opcode in bits [6:0]):
  - R: opcode 0110011 = {funct7, rs2, rs1, funct3, rd, op}.
  - I: opcode 0010011 = {imm[11:0], rs1, funct3, rd, op}.
  - LOAD: opcode 0000011, same packing as I.
  - S: opcode 0100011 = {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
  - B: opcode 1100011 = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
  - J: opcode 1101111 = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
  - NOP = 0x00000013.
  - Illegal fmt: encode NOP and set err.
- Output side:
  - imem_we = FIFO not empty and state is RUN or DRAIN; imem_wdata = FIFO head.
  - On imem_we && imem_ready: pop the FIFO, imem_addr += 4, count += 1.
  - While imem_ready=0, imem_we, imem_addr and imem_wdata hold stable.
- Latency: a bundle accepted in cycle N appears on imem_we in cycle N+1 at the earliest.
- Boundary conditions:
  - Push and pop in the same cycle when full: allowed only if the pop occurs; in_ready is computed from registered full and does not depend on imem_ready.
  - Push and pop in the same cycle when empty: not a bypass; the word is written the following cycle.
  - imem_addr wraps modulo 2^ADDR_W.
  - count saturates at 0xFFFF.
  - Reset mid-operation: FIFO is flushed and the pending write is dropped with no partial write.
  - in_last on an illegal fmt still ends the program.

Optional Feature:
- Macro: INSTR_ENCODER_RANGE_CHECK_EN.
- With the macro defined, err is also set when:
  - imm does not fit the signed field width: 12 bits for I/LOAD/S, 13 bits for B, 21 bits for J;
  - imm[0]=1 for B or J.
  - The word is still encoded, truncated.
- Without the macro: silent truncation, and err is set only for illegal fmt.

Decomposition:
- Shared package instr_pkg holds the fmt enum values, the opcode constants (OP_R, OP_I, OP_LOAD, OP_S, OP_B, OP_J), NOP_WORD, and the encoder state encodings; the decoder shares the same constants.
- One sub-module, instr_fifo: DEPTH-entry, 32-bit synchronous FIFO with push, pop, full and empty.
- Field packing stays in a combinational function inside instr_encoder.

Test Plan:
- start with base 0x100, send I-type rd=1, rs1=0, f3=0, imm=5 with in_last -> write 0x00500093 at 0x100, done pulse, count=1.
- Send R-type rd=3, rs1=1, rs2=2, f3=0, f7=0, then S-type rs1=1, rs2=2, f3=010, imm=8 -> writes 0x002081B3 and 0x0020A423 at consecutive addresses.
- Send B-type rs1=1, rs2=2, f3=0, imm=8, then J-type rd=1, imm=16 -> writes 0x00208463 and 0x010000EF.
- Hold imem_ready=0 and send 5 bundles with DEPTH=4 -> in_ready drops after 4 are accepted, outputs hold stable, no words are lost after imem_ready is released.
- fmt=7 -> writes 0x00000013 and sets err; with INSTR_ENCODER_RANGE_CHECK_EN, an I-type with imm=2048 also sets err.
- Assert rst_n low mid-DRAIN with 2 words queued -> all outputs return to reset values, no further imem_we, and a following start works normally.
